exec_accum_buf: RTL and testbench
=================================

Name: exec_accum_buf

Overview:
Parametrised ping-pong reduction buffer for the GCN execute back-end. Writes from the MAC array arrive PIPE_LAT cycles after issue. The block aligns the issue-time control with that data internally and supports both overwrite and saturating-accumulate writes. A handshaked bank swap drains in-flight writes before flipping banks, and the read bank is served with registered 1-cycle latency.

Parameters:
LANES, 16, number of data lanes per row
DW, 16, signed lane width in bits
DEPTH, 256, rows per bank
AW, $clog2(DEPTH), row address width
PIPE_LAT, 2, cycles from issue to x_data arrival (≥1)
CLEAR_ON_SWAP, 1, when 1 a swap invalidates every row of the new write bank

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  issue strobe, sampled with in_ready
in_ready  out  1  issue accepted when in_valid&&in_ready
in_addr  in  AW  destination row, issue-time
in_acc  in  1  0=overwrite, 1=accumulate, issue-time
x_data  in  LANES*DW  MAC result for the issue made PIPE_LAT cycles earlier
swap_req  in  1  single-cycle swap request
swap_done  out  1  1-cycle pulse: banks flipped
w_bank  out  1  current write bank index (read bank = ~w_bank)
r_en  in  1  read strobe on read bank
r_addr  in  AW  read row
r_data  out  LANES*DW  read data
r_valid  out  1  r_data valid
sat_flag  out  1  sticky: any lane saturated since last swap

Behaviour:
- Reset, sampled at a clock edge while reset=1: w_bank=0, all row-valid bits in both banks 0, state IDLE, delay line empty, swap_done=0, r_valid=0, r_data=0, sat_flag=0. in_ready=0 while reset=1.
- Storage: 2×DEPTH×LANES×DW flops plus a 2×DEPTH row-valid bitmap. A row whose valid bit is 0 reads as 0.
- Delay line: PIPE_LAT stages of {valid, addr, acc}. Stage 0 is loaded with {in_valid&&in_ready, in_addr, in_acc}. The final stage pairs with x_data in the same cycle.
- Write, at the edge ending the final-stage cycle when stage valid=1:
  - acc=0: row := x_data.
  - acc=1: per lane, row := sat(old + x), computed at DW+1 bits. old=0 if the row is invalid.
  - Saturation clamps to +2^(DW-1)-1 / -2^(DW-1). Any clamp sets sat_flag.
  - Row valid bit := 1.
- Consecutive accumulates to the same row on back-to-back cycles must each see the previous result. No forwarding stall is allowed; throughput is 1 row/cycle.
- Read: r_en at cycle t gives r_valid=1 and r_data=row(~w_bank, r_addr) at t+1. r_valid=0 and r_data holds its value when r_en=0. Reads never touch the write bank.
- Swap FSM:
  - IDLE: in_ready=1. swap_req → DRAIN. An issue in the same cycle as swap_req is accepted and drained.
  - DRAIN: in_ready=0. swap_req is ignored. When every delay-line valid is 0 at an edge:
    - w_bank flips.
    - If CLEAR_ON_SWAP, all valid bits of the new write bank clear.
    - sat_flag clears.
    - swap_done=1 for the next cycle.
    - State → IDLE.
- A read in the cycle of the flip edge returns pre-flip read-bank data. The next cycle reads the new read bank.
- Reset asserted mid-DRAIN or mid-write aborts immediately to the reset state; in-flight writes are lost.
- Address ≥ DEPTH (non-power-of-2 DEPTH): write dropped, read returns 0.
- x_data is ignored when the final-stage valid is 0.

Test Plan:
- Reset then overwrite: PIPE_LAT=2, issue addr 5, acc=0 at t, x_data lanes=0x0011 at t+2, swap_req at t+3 → swap_done at t+5. Read addr 5 → r_data lanes 0x0011 one cycle later.
- Accumulate chain: issues to addr 3 on 3 consecutive cycles (acc=0,1,1) with x=1,2,3 per lane; swap; read 3 → 6 per lane, sat_flag=0.
- Saturation: overwrite 0x7FF0, then accumulate 0x0020 → 0x7FFF and sat_flag=1. Accumulate 0x8000 onto 0x8001 → 0x8000 (-32768). Swap → sat_flag=0.
- Swap drain: issue at t with swap_req at t → in_ready=0 from t+1, write lands at end of t+2, flip at end of t+3, swap_done=1 at t+4, w_bank toggled at t+4. A swap_req pulse at t+2 has no extra effect.
- CLEAR_ON_SWAP=1: fill bank rows, swap twice, accumulate x=4 into a previously written row → reads 4, not old+4. Repeat with CLEAR_ON_SWAP=0 → reads old+4.
- Reset mid-DRAIN: assert reset during DRAIN with a write in flight → w_bank=0, in_ready=0 during reset, no swap_done, all reads return 0 afterwards.

Source files
------------

// File: rtl/exec_accum_buf.sv
// Ping-pong reduction buffer: delayed overwrite/saturating-accumulate writes into
// the write bank, registered reads from the other bank, handshaked drain-then-swap.
module exec_accum_buf #(
    parameter int LANES         = 16,
    parameter int DW            = 16,
    parameter int DEPTH         = 256,
    parameter int AW            = $clog2(DEPTH),
    parameter int PIPE_LAT      = 2,
    parameter int CLEAR_ON_SWAP = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AW-1:0]         in_addr,
    input  logic                  in_acc,
    input  logic [LANES*DW-1:0]   x_data,
    input  logic                  swap_req,
    output logic                  swap_done,
    output logic                  w_bank,
    input  logic                  r_en,
    input  logic [AW-1:0]         r_addr,
    output logic [LANES*DW-1:0]   r_data,
    output logic                  r_valid,
    output logic                  sat_flag
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    state_t                r_state, w_state_nx;
    logic                  r_wbank;
    logic [DEPTH-1:0]      r_vld [2];
    logic [LANES*DW-1:0]   r_mem [2][DEPTH];
    logic [PIPE_LAT-1:0]   r_dv;
    logic [PIPE_LAT-1:0]   r_dacc;
    logic [AW-1:0]         r_da [PIPE_LAT];
    logic                  r_swap_done, r_rvalid, r_sat;
    logic [LANES*DW-1:0]   r_rdata;

    logic                  w_flip, w_issue, w_rbank;
    logic                  w_fv, w_facc, w_we, w_any_sat;
    logic [AW-1:0]         w_fa;
    logic [LANES*DW-1:0]   w_old, w_new, w_rd;
    logic [LANES-1:0]      w_ovf;

    always_comb begin
        w_state_nx = r_state;
        w_flip     = 1'b0;
        in_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = !reset;
                if (swap_req) w_state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_dv == '0) begin
                    w_flip     = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign w_issue = in_valid && in_ready;

    // Issue-time control travels alongside the MAC pipeline so it meets x_data.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dv <= '0;
        end else begin
            r_dv[0] <= w_issue;
            for (int i = 1; i < PIPE_LAT; i++) r_dv[i] <= r_dv[i-1];
        end
    end

    always_ff @(posedge clock) begin
        r_da[0]   <= in_addr;
        r_dacc[0] <= in_acc;
        for (int i = 1; i < PIPE_LAT; i++) begin
            r_da[i]   <= r_da[i-1];
            r_dacc[i] <= r_dacc[i-1];
        end
    end

    assign w_fv   = r_dv[PIPE_LAT-1];
    assign w_fa   = r_da[PIPE_LAT-1];
    assign w_facc = r_dacc[PIPE_LAT-1];
    assign w_we   = w_fv && ({1'b0, w_fa} < DEPTH_W);

    // Reading old data straight from the array at write time lets back-to-back
    // accumulates see the previous result without any forwarding path.
    assign w_old = r_vld[r_wbank][w_fa] ? r_mem[r_wbank][w_fa] : '0;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DW:0]   w_sum;
        logic [DW-1:0] w_clamp;
        assign w_sum   = {w_old[l*DW+DW-1], w_old[l*DW +: DW]}
                       + {x_data[l*DW+DW-1], x_data[l*DW +: DW]};
        assign w_ovf[l] = w_sum[DW] ^ w_sum[DW-1];
        assign w_clamp = w_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        assign w_new[l*DW +: DW] = !w_facc  ? x_data[l*DW +: DW] :
                                   w_ovf[l] ? w_clamp : w_sum[DW-1:0];
    end

    assign w_any_sat = w_we && w_facc && (|w_ovf);

    always_ff @(posedge clock) begin
        if (w_we) r_mem[r_wbank][w_fa] <= w_new;
    end

    assign w_rbank = ~r_wbank;
    assign w_rd    = (({1'b0, r_addr} < DEPTH_W) && r_vld[w_rbank][r_addr])
                   ? r_mem[w_rbank][r_addr] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wbank     <= 1'b0;
            r_vld[0]    <= '0;
            r_vld[1]    <= '0;
            r_swap_done <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_sat       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_swap_done <= w_flip;
            r_rvalid    <= r_en;
            if (r_en) r_rdata <= w_rd;
            if (w_we) r_vld[r_wbank][w_fa] <= 1'b1;
            // Flip only happens with the delay line empty, so it never meets a write.
            if (w_flip) begin
                r_wbank <= ~r_wbank;
                r_sat   <= 1'b0;
                if (CLEAR_ON_SWAP != 0) r_vld[w_rbank] <= '0;
            end else if (w_any_sat) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign swap_done = r_swap_done;
    assign w_bank    = r_wbank;
    assign r_data    = r_rdata;
    assign r_valid   = r_rvalid;
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_exec_accum_buf.sv
// Directed bench for exec_accum_buf: two instances (clear-on-swap on/off, DEPTH=12)
// share stimulus; expected values are hand-computed.
module tb_exec_accum_buf;
    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 12;
    localparam int AW    = 4;
    localparam int W     = LANES*DW;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid, in_acc, swap_req, r_en;
    logic [AW-1:0] in_addr, r_addr;
    logic [W-1:0]  x_data;

    logic          rdy_k, sd_k, wb_k, rv_k, sat_k;
    logic          rdy_n, sd_n, wb_n, rv_n, sat_n;
    logic [W-1:0]  rd_k, rd_n;

    int            vecs = 0;
    int            miss = 0;
    logic [W-1:0]  xq0, xq1;

    always #5 clock = ~clock;

    exec_accum_buf #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH), .PIPE_LAT(2), .CLEAR_ON_SWAP(1)) u_k (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_k),
        .in_addr(in_addr), .in_acc(in_acc), .x_data(x_data), .swap_req(swap_req),
        .swap_done(sd_k), .w_bank(wb_k), .r_en(r_en), .r_addr(r_addr),
        .r_data(rd_k), .r_valid(rv_k), .sat_flag(sat_k));

    exec_accum_buf #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH), .PIPE_LAT(2), .CLEAR_ON_SWAP(0)) u_n (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_n),
        .in_addr(in_addr), .in_acc(in_acc), .x_data(x_data), .swap_req(swap_req),
        .swap_done(sd_n), .w_bank(wb_n), .r_en(r_en), .r_addr(r_addr),
        .r_data(rd_n), .r_valid(rv_n), .sat_flag(sat_n));

    function automatic logic [W-1:0] rep(input logic [15:0] v);
        return {LANES{v}};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle; x supplied here reaches x_data two cycles later.
    task automatic step(input logic v, input logic [AW-1:0] a, input logic acc,
                        input logic [15:0] x, input logic sw, input logic re,
                        input logic [AW-1:0] ra);
        in_valid = v; in_addr = a; in_acc = acc; swap_req = sw;
        r_en = re; r_addr = ra; x_data = xq1;
        @(posedge clock);
        #1;
        xq1 = xq0;
        xq0 = rep(x);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 16'hDEAD, 1'b0, 1'b0, '0);
    endtask

    task automatic swp();
        step(1'b0, '0, 1'b0, 16'hDEAD, 1'b1, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] ek,
                      input logic [W-1:0] en, input string tag);
        step(1'b0, '0, 1'b0, 16'hDEAD, 1'b0, 1'b1, a);
        chk({tag, "_vk"}, W'(rv_k), W'(1));
        chk({tag, "_vn"}, W'(rv_n), W'(1));
        chk({tag, "_dk"}, rd_k, ek);
        chk({tag, "_dn"}, rd_n, en);
    endtask

    task automatic wait_swap(input string tag);
        int n = 0;
        while (!sd_k && n < 8) begin
            idle();
            n++;
        end
        chk({tag, "_done_k"}, W'(sd_k), W'(1));
        chk({tag, "_done_n"}, W'(sd_n), W'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        xq0 = rep(16'hDEAD); xq1 = rep(16'hDEAD);
        reset = 1'b1;
        idle(); idle();
        chk("rst_rdy", W'(rdy_k), W'(0));
        chk("rst_wb", W'(wb_k), W'(0));
        chk("rst_sd", W'(sd_k), W'(0));
        chk("rst_rv", W'(rv_k), W'(0));
        chk("rst_rd", rd_k, '0);
        chk("rst_sat", W'(sat_k), W'(0));
        reset = 1'b0;
        idle();
        chk("idle_rdy_k", W'(rdy_k), W'(1));
        chk("idle_rdy_n", W'(rdy_n), W'(1));

        // Overwrite row 5, swap at t+3, done at t+5; issue during DRAIN is dropped.
        step(1'b1, 4'd5, 1'b0, 16'h0011, 1'b0, 1'b0, '0);
        idle(); idle();
        swp();
        chk("drain_rdy", W'(rdy_k), W'(0));
        step(1'b1, 4'd9, 1'b0, 16'h7777, 1'b0, 1'b0, '0);
        chk("ow_sd", W'(sd_k), W'(1));
        chk("ow_wb", W'(wb_k), W'(1));
        idle();
        chk("ow_sd_pulse", W'(sd_k), W'(0));
        rd(4'd5, rep(16'h0011), rep(16'h0011), "ow_rd5");
        idle();
        chk("rd_idle_rv", W'(rv_k), W'(0));
        chk("rd_hold", rd_k, rep(16'h0011));

        // Back-to-back accumulate chain into row 3 of bank 1.
        step(1'b1, 4'd3, 1'b0, 16'd1, 1'b0, 1'b0, '0);
        step(1'b1, 4'd3, 1'b1, 16'd2, 1'b0, 1'b0, '0);
        step(1'b1, 4'd3, 1'b1, 16'd3, 1'b0, 1'b0, '0);
        idle(); idle();
        chk("acc_sat", W'(sat_k), W'(0));
        swp();
        wait_swap("acc");
        chk("acc_wb", W'(wb_k), W'(0));
        rd(4'd3, rep(16'd6), rep(16'd6), "acc_rd3");
        rd(4'd9, '0, '0, "drain_drop_rd9");
        rd(4'd5, '0, '0, "acc_rd5");

        // Saturation both directions.
        step(1'b1, 4'd7, 1'b0, 16'h7FF0, 1'b0, 1'b0, '0);
        step(1'b1, 4'd7, 1'b1, 16'h0020, 1'b0, 1'b0, '0);
        step(1'b1, 4'd8, 1'b0, 16'h8001, 1'b0, 1'b0, '0);
        step(1'b1, 4'd8, 1'b1, 16'h8000, 1'b0, 1'b0, '0);
        idle(); idle();
        chk("sat_k", W'(sat_k), W'(1));
        chk("sat_n", W'(sat_n), W'(1));
        swp();
        wait_swap("sat");
        chk("sat_clr", W'(sat_k), W'(0));
        rd(4'd7, rep(16'h7FFF), rep(16'h7FFF), "sat_pos");
        rd(4'd8, rep(16'h8000), rep(16'h8000), "sat_neg");

        // Issue together with swap_req; exact drain timing, second request ignored.
        step(1'b1, 4'd2, 1'b0, 16'h1234, 1'b1, 1'b0, '0);
        chk("sw_rdy", W'(rdy_k), W'(0));
        idle();
        swp();
        step(1'b0, '0, 1'b0, 16'hDEAD, 1'b0, 1'b1, 4'd7);
        chk("sw_sd", W'(sd_k), W'(1));
        chk("sw_wb", W'(wb_k), W'(0));
        chk("flip_rd_k", rd_k, rep(16'h7FFF));
        chk("flip_rd_n", rd_n, rep(16'h7FFF));
        rd(4'd2, rep(16'h1234), rep(16'h1234), "sw_rd2");
        chk("sw_sd_pulse", W'(sd_k), W'(0));
        rd(4'd3, '0, rep(16'd6), "clr_rd3");
        idle(); idle();
        chk("sw_no_extra", W'(wb_k), W'(0));
        chk("sw_rdy_back", W'(rdy_k), W'(1));

        // Accumulate into a row written before two swaps; out-of-range write.
        step(1'b1, 4'd5, 1'b1, 16'h0004, 1'b0, 1'b0, '0);
        step(1'b1, 4'd13, 1'b0, 16'h5555, 1'b0, 1'b0, '0);
        idle(); idle();
        swp();
        wait_swap("clr");
        rd(4'd5, rep(16'h0004), rep(16'h0015), "clr_acc5");
        rd(4'd13, '0, '0, "oor_rd13");
        rd(4'd1, '0, '0, "oor_alias1");

        // Reset during DRAIN with a write in flight.
        step(1'b1, 4'd4, 1'b0, 16'h2222, 1'b1, 1'b0, '0);
        chk("mr_drain", W'(rdy_k), W'(0));
        reset = 1'b1;
        idle();
        chk("mr_wb", W'(wb_k), W'(0));
        chk("mr_rdy", W'(rdy_k), W'(0));
        chk("mr_sd", W'(sd_k), W'(0));
        idle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("mr_no_sd", W'(sd_k), W'(0));
        end
        chk("mr_wb_after", W'(wb_k), W'(0));
        rd(4'd4, '0, '0, "mr_rd4");
        rd(4'd2, '0, '0, "mr_rd2");
        rd(4'd3, '0, '0, "mr_rd3");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
